// File: rtl/tage_t0_updater.sv
// TAGE T0 bimodal table updater: 1-cycle read-modify-write pipe plus a full-table clear sweep.
// Optional macro TAGE_T0_FWD_EN: forward same-index back-to-back updates instead of stalling.
module tage_t0_updater #(
  parameter int num_entries = 512,
  parameter int addr_width  = $clog2(num_entries),
  parameter int data_width  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [addr_width-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  clear_req,
  output logic                  clear_done,
  output logic                  busy,
  output logic [addr_width-1:0] ram_raddr,
  input  logic [data_width-1:0] ram_q,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_waddr,
  output logic [data_width-1:0] ram_wdata
);

  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } state_t;

  localparam logic [data_width-1:0] CMAX = '1;
  localparam logic [data_width-1:0] CMIN = '0;
  localparam logic [data_width-1:0] CLR_VAL =
    data_width'((1 << (data_width - 1)) - 1);
  localparam logic [addr_width-1:0] LAST =
    addr_width'(num_entries - 1);

  state_t                r_state;
  logic                  r_s1_valid;
  logic [addr_width-1:0] r_s1_idx;
  logic                  r_s1_taken;
  logic                  r_s1_fwd;
  logic [data_width-1:0] r_s1_fwdval;
  logic [addr_width-1:0] r_clear_ptr;

  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_in_clear;
  logic                  w_last;
  logic [data_width-1:0] w_old;
  logic [data_width-1:0] w_new;

  always_comb begin
    w_hazard = r_s1_valid && (upd_idx == r_s1_idx);
`ifdef TAGE_T0_FWD_EN
    w_stall = 1'b0;
`else
    w_stall = w_hazard;
`endif
  end

  assign w_in_clear = (r_state == ST_CLEAR);
  assign w_last     = (r_clear_ptr == LAST);

  assign upd_ready = !rst && !w_in_clear
                   && !clear_req && !w_stall;
  assign w_accept  = upd_valid && upd_ready;

  // A forwarded value stands in for RAM data that is still being written
  assign w_old = r_s1_fwd ? r_s1_fwdval : ram_q;

  always_comb begin
    w_new = w_old;
    if (r_s1_taken) begin
      if (w_old != CMAX) w_new = w_old + 1'b1;
    end else begin
      if (w_old != CMIN) w_new = w_old - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_taken  <= 1'b0;
      r_s1_fwd    <= 1'b0;
      r_s1_fwdval <= '0;
      r_clear_ptr <= '0;
    end else begin
      r_s1_valid  <= w_accept;
      r_s1_fwdval <= w_new;
      if (w_accept) begin
        r_s1_idx   <= upd_idx;
        r_s1_taken <= upd_taken;
      end
`ifdef TAGE_T0_FWD_EN
      r_s1_fwd <= w_accept && w_hazard;
`else
      r_s1_fwd <= 1'b0;
`endif
      unique case (r_state)
        ST_RUN: begin
          if (clear_req) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (w_last) begin
            r_clear_ptr <= '0;
            r_state     <= ST_RUN;
          end else begin
            r_clear_ptr <= r_clear_ptr + 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign ram_raddr  = upd_idx;
  assign busy       = !rst && w_in_clear;
  assign clear_done = !rst && w_in_clear && w_last;
  assign ram_we     = !rst && (w_in_clear || r_s1_valid);
  assign ram_waddr  = w_in_clear ? r_clear_ptr : r_s1_idx;
  assign ram_wdata  = w_in_clear ? CLR_VAL : w_new;

endmodule

// File: tb/tb_tage_t0_updater.sv
// Scoreboard bench for tage_t0_updater with a behavioural 1-cycle-read RAM.
// Directed updates, back-to-back hazard, clear sweep and reset-abort.
module tb_tage_t0_updater;

  localparam int NE = 512;
  localparam int AW = 9;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [AW-1:0] upd_idx = '0;
  logic          upd_taken = 1'b0;
  logic          clear_req = 1'b0;
  logic          clear_done;
  logic          busy;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_q = '0;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  logic [DW-1:0] mem [NE];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          done;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  tage_t0_updater #(
    .num_entries(NE),
    .addr_width (AW),
    .data_width (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .clear_req (clear_req),
    .clear_done(clear_done),
    .busy      (busy),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // Monitor: every DUT write must match the next expected write
  always @(negedge clk) begin
    if (ram_we) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got a=%0d d=%0b exp none",
                 ram_waddr, ram_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ram_waddr !== e.a || ram_wdata !== e.d
            || clear_done !== e.done) begin
          n_fail++;
          $display("FAIL write got a=%0d d=%0b done=%0b exp a=%0d d=%0b done=%0b",
                   ram_waddr, ram_wdata, clear_done, e.a, e.d, e.done);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push(input int a, input int d, input bit done);
    exp_t e;
    e.a = AW'(a);
    e.d = DW'(d);
    e.done = done;
    q.push_back(e);
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) push(i, 1, (i == NE - 1));
  endtask

  task automatic upd(input int idx, input bit tk, input int exp);
    upd_valid = 1'b1;
    upd_idx   = AW'(idx);
    upd_taken = tk;
    @(negedge clk);
    chk("upd_ready", upd_ready, 1);
    if (upd_ready) push(idx, exp, 1'b0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(negedge clk);
    chk("latency_we", ram_we, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_clear(input string nm);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!busy && cnt > 0) break;
      if (busy) begin
        cnt++;
        if (upd_ready) bad++;
      end
      if (c == 50) clear_req = 1'b1;
      if (c == 51) clear_req = 1'b0;
    end
    @(posedge clk); #1;
    chk({nm, "_busy_cycles"}, cnt, NE);
    chk({nm, "_ready_in_clear"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int exp_rdy;
    for (int i = 0; i < NE; i++) mem[i] = 2'b01;
    mem[5] = 2'b01;
    mem[7] = 2'b11;
    mem[3] = 2'b10;
    mem[4] = 2'b11;
    mem[9] = 2'b00;
    mem[20] = 2'b01;

    repeat (2) @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear_done", clear_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", upd_ready, 1);
    @(posedge clk); #1;

    upd(5, 1'b1, 2);
    upd(7, 1'b1, 3);
    mem[7] = 2'b00;
    upd(7, 1'b0, 0);
    upd(7, 1'b1, 1);
    upd(3, 1'b0, 1);
    upd(4, 1'b0, 2);

    // Back-to-back same index from 00
    upd_valid = 1'b1;
    upd_idx   = 9;
    upd_taken = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
`ifdef TAGE_T0_FWD_EN
      exp_rdy = 1;
`else
      exp_rdy = (c % 2 == 0) ? 1 : 0;
`endif
      chk("b2b_ready", upd_ready, exp_rdy);
      if (upd_ready) begin
        n++;
        push(9, n, 1'b0);
      end
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    chk("b2b_accepts", n, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_final", mem[9], 3);

    // Update then clear_req on the next cycle
    upd_valid = 1'b1;
    upd_idx   = 20;
    upd_taken = 1'b1;
    @(negedge clk);
    chk("pre_clear_ready", upd_ready, 1);
    push(20, 2, 1'b0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    clear_req = 1'b1;
    push_clear(NE);
    @(negedge clk);
    chk("clear_req_ready", upd_ready, 0);
    chk("clear_req_busy", busy, 0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_clear("clear1");

    // Reset in the middle of a clear sweep
    clear_req = 1'b1;
    push_clear(100);
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", ram_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_we", ram_we, 0);
    chk("post_rst_ready", upd_ready, 1);
    @(posedge clk); #1;
    clear_req = 1'b1;
    push_clear(NE);
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_clear("clear2");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
